// File: rtl/instruction_loader.sv
// Receives a byte stream, assembles big-endian 32-bit instructions and writes
// them to instruction memory until HALT_WORD is seen or the memory is full.
module instruction_loader #(
  parameter int          PC_SIZE   = 32,
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  localparam int         CNT_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_wr_en,
  output logic [PC_SIZE-1:0] o_wr_addr,
  output logic [31:0]        o_wr_data,
  output logic               o_clear_pc,
  output logic               o_done,
  output logic               o_error,
  output logic [CNT_W-1:0]   o_word_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEIVE = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_DEPTH);

  state_t             state_q;
  logic [1:0]         byte_cnt_q;
  logic [31:0]        asm_q;
  logic               wr_en_q;
  logic [PC_SIZE-1:0] wr_addr_q;
  logic [31:0]        wr_data_q;
  logic               clear_pc_q;
  logic               done_q;
  logic               error_q;
  logic [CNT_W-1:0]   word_count_q;

  logic [31:0]        asm_d;
  logic [CNT_W-1:0]   word_count_d;

  assign asm_d        = {asm_q[23:0], i_rx_data};
  assign word_count_d = word_count_q + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clear_pc_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else if (i_abort) begin
      // Abort behaves like a synchronous reset so a pending write never issues.
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      clear_pc_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            state_q      <= RECEIVE;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            clear_pc_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end

        RECEIVE: begin
          if (i_rx_valid) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              wr_data_q <= asm_d;
            end
          end
        end

        WRITE: begin
          wr_en_q      <= 1'b0;
          word_count_q <= word_count_d;
          // Address saturates at the last word so it never points past memory.
          if (word_count_q != LAST_IDX) begin
            wr_addr_q <= wr_addr_q + PC_SIZE'(4);
          end
          if (wr_data_q == HALT_WORD) begin
            state_q    <= DONE;
            clear_pc_q <= 1'b0;
            done_q     <= 1'b1;
          end else if (word_count_d == FULL_CNT) begin
            state_q    <= ERROR;
            clear_pc_q <= 1'b0;
            error_q    <= 1'b1;
          end else begin
            state_q <= RECEIVE;
            // A byte arriving now is the first byte of the next word.
            if (i_rx_valid) begin
              asm_q      <= asm_d;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        default: begin
          state_q    <= IDLE;
          wr_en_q    <= 1'b0;
          clear_pc_q <= 1'b0;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_clear_pc   = clear_pc_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed table-driven bench for instruction_loader (MEM_DEPTH=4 so the
// memory-full path is reachable), plus a hand-written async-reset sequence.
module tb_instruction_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        clear_pc;
  logic        done;
  logic        error;
  logic [2:0]  word_count;

  int checks = 0;
  int failures = 0;

  instruction_loader #(
    .PC_SIZE  (32),
    .MEM_DEPTH(4),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_clear_pc  (clear_pc),
    .o_done      (done),
    .o_error     (error),
    .o_word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output image: {wr_en, addr, data, clear_pc, done, error, count}
  typedef struct {
    logic        s;
    logic        a;
    logic        v;
    logic [7:0]  d;
    logic [70:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [70:0] e(input logic en, input logic [31:0] addr,
                                    input logic [31:0] data, input logic cpc,
                                    input logic dn, input logic er,
                                    input logic [2:0] cnt);
    return {en, addr, data, cpc, dn, er, cnt};
  endfunction

  function automatic logic [70:0] outs();
    return {wr_en, wr_addr, wr_data, clear_pc, done, error, word_count};
  endfunction

  task automatic add(input logic s, input logic a, input logic v,
                     input logic [7:0] d, input logic [70:0] exp);
    vec_t t;
    t.s = s; t.a = a; t.v = v; t.d = d; t.exp = exp;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [70:0] exp);
    logic [70:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got en=%0b addr=%h data=%h cpc=%0b done=%0b err=%0b cnt=%0d, want en=%0b addr=%h data=%h cpc=%0b done=%0b err=%0b cnt=%0d",
               name, got[70], got[69:38], got[37:6], got[5], got[4], got[3], got[2:0],
               exp[70], exp[69:38], exp[37:6], exp[5], exp[4], exp[3], exp[2:0]);
    end else begin
      $display("ok   %s: en=%0b addr=%h data=%h cpc=%0b done=%0b err=%0b cnt=%0d",
               name, got[70], got[69:38], got[37:6], got[5], got[4], got[3], got[2:0]);
    end
  endtask

  // Drive at negedge, let one rising edge consume it, check at next negedge.
  task automatic apply(input string name, input vec_t t);
    start = t.s; abort = t.a; rx_valid = t.v; rx_data = t.d;
    @(negedge clk);
    check(name, t.exp);
  endtask

  localparam logic [70:0] ZERO = 71'd0;

  initial begin
    // Writes of word 0 / 1 / halt at 0, 4, 8; byte in WRITE cycle starts next word
    add(1, 0, 0, 8'h00, e(0, 0,  32'h0,         1, 0, 0, 0));
    add(0, 0, 1, 8'h20, e(0, 0,  32'h0,         1, 0, 0, 0));
    add(0, 0, 1, 8'h01, e(0, 0,  32'h0,         1, 0, 0, 0));
    add(0, 0, 1, 8'h00, e(0, 0,  32'h0,         1, 0, 0, 0));
    add(0, 0, 1, 8'h05, e(1, 0,  32'h2001_0005, 1, 0, 0, 0));
    add(0, 0, 1, 8'hAA, e(0, 4,  32'h2001_0005, 1, 0, 0, 1));
    add(0, 0, 1, 8'hBB, e(0, 4,  32'h2001_0005, 1, 0, 0, 1));
    add(0, 0, 1, 8'hCC, e(0, 4,  32'h2001_0005, 1, 0, 0, 1));
    add(0, 0, 1, 8'hDD, e(1, 4,  32'hAABB_CCDD, 1, 0, 0, 1));
    add(1, 0, 1, 8'hFF, e(0, 8,  32'hAABB_CCDD, 1, 0, 0, 2));
    add(0, 0, 1, 8'hFF, e(0, 8,  32'hAABB_CCDD, 1, 0, 0, 2));
    add(0, 0, 1, 8'hFF, e(0, 8,  32'hAABB_CCDD, 1, 0, 0, 2));
    add(0, 0, 1, 8'hFF, e(1, 8,  32'hFFFF_FFFF, 1, 0, 0, 2));
    add(0, 0, 1, 8'h55, e(0, 12, 32'hFFFF_FFFF, 0, 1, 0, 3));
    add(0, 0, 1, 8'h66, e(0, 12, 32'hFFFF_FFFF, 0, 1, 0, 3));
    // Restart from DONE overwrites from address 0
    add(1, 0, 0, 8'h00, e(0, 0,  32'hFFFF_FFFF, 1, 0, 0, 0));
    add(0, 0, 1, 8'h01, e(0, 0,  32'hFFFF_FFFF, 1, 0, 0, 0));
    add(0, 0, 1, 8'h02, e(0, 0,  32'hFFFF_FFFF, 1, 0, 0, 0));
    add(0, 0, 1, 8'h03, e(0, 0,  32'hFFFF_FFFF, 1, 0, 0, 0));
    add(0, 0, 1, 8'h04, e(1, 0,  32'h0102_0304, 1, 0, 0, 0));
    add(0, 0, 0, 8'h00, e(0, 4,  32'h0102_0304, 1, 0, 0, 1));
    // Fill remaining memory without a halt word -> ERROR, addr stays at 12
    for (int w = 1; w < 4; w++) begin
      logic [7:0] b;
      b = 8'(w * 16);
      for (int k = 0; k < 4; k++)
        add(k == 0, 0, 1, b, e(k == 3, 32'(4 * w), (k == 3) ? {4{b}} : 32'(w == 1 ? 32'h0102_0304 : {4{8'(b - 8'h10)}}),
                             1, 0, 0, 3'(w)));
      if (w < 3) add(0, 0, 0, 8'h00, e(0, 32'(4 * (w + 1)), {4{b}}, 1, 0, 0, 3'(w + 1)));
    end
    add(0, 0, 0, 8'h00, e(0, 12, 32'h3030_3030, 0, 0, 1, 4));
    for (int k = 0; k < 4; k++) add(0, 0, 1, 8'h40, e(0, 12, 32'h3030_3030, 0, 0, 1, 4));
    add(0, 1, 0, 8'h00, ZERO);
    // Abort after two bytes, abort beats start, then a clean load from 0
    add(1, 0, 0, 8'h00, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'h12, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'h34, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 1, 1, 8'h56, ZERO);
    add(0, 0, 1, 8'h56, ZERO);
    add(1, 1, 0, 8'h00, ZERO);
    add(1, 0, 0, 8'h00, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'h9A, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'hBC, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'hDE, e(0, 0, 32'h0, 1, 0, 0, 0));
    add(0, 0, 1, 8'hF0, e(1, 0, 32'h9ABC_DEF0, 1, 0, 0, 0));
    add(0, 1, 0, 8'h00, ZERO);

    rst = 1'b1; start = 0; abort = 0; rx_valid = 0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", ZERO);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", ZERO);

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset mid-word: outputs clear before any clock edge
    begin
      vec_t t;
      t.s = 1; t.a = 0; t.v = 0; t.d = 8'h00; t.exp = e(0, 0, 32'h0, 1, 0, 0, 0);
      apply("ar_start", t);
      t.s = 0; t.v = 1; t.d = 8'h77;
      apply("ar_byte0", t);
      t.d = 8'h88;
      apply("ar_byte1", t);
      rx_valid = 0;
      #2 rst = 1'b1;
      #1 check("async_reset", ZERO);
      @(negedge clk);
      rst = 1'b0;
      t.v = 0;
      t.exp = ZERO;
      apply("ar_idle", t);
      t.s = 1; t.exp = e(0, 0, 32'h0, 1, 0, 0, 0);
      apply("ar_restart", t);
      t.s = 0; t.v = 1; t.d = 8'h01;
      apply("ar_b0", t);
      t.d = 8'h23;
      apply("ar_b1", t);
      t.d = 8'h45;
      apply("ar_b2", t);
      t.d = 8'h67; t.exp = e(1, 0, 32'h0123_4567, 1, 0, 0, 0);
      apply("ar_write", t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter PC_SIZE, default 32: width of the instruction-memory byte address.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 64: capacity of instruction memory in 32-bit words.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that terminates a program.
REQ-004 The block SHALL have port i_clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_start, input, 1 bit: request to begin a program load.
REQ-007 The block SHALL have port i_abort, input, 1 bit: cancels any load and returns the block to IDLE.
REQ-008 The block SHALL have port i_rx_data, input, 8 bits: received program byte.
REQ-009 The block SHALL have port i_rx_valid, input, 1 bit: i_rx_data is valid this cycle; one byte per asserted cycle.
REQ-010 The block SHALL have port o_wr_en, output, 1 bit: instruction-memory write strobe.
REQ-011 The block SHALL have port o_wr_addr, output, PC_SIZE bits: byte address for the write.
REQ-012 The block SHALL have port o_wr_data, output, 32 bits: instruction word to write.
REQ-013 The block SHALL have port o_clear_pc, output, 1 bit: held high while loading so the PC stays at 0.
REQ-014 The block SHALL have port o_done, output, 1 bit: program loaded, HALT_WORD written.
REQ-015 The block SHALL have port o_error, output, 1 bit: memory filled without HALT_WORD.
REQ-016 The block SHALL have port o_word_count, output, clog2(MEM_DEPTH)+1 bits: number of words written.

Function
REQ-017 The FSM SHALL have the states IDLE, RECEIVE, WRITE, DONE and ERROR.
REQ-018 In IDLE with i_start=1, the FSM SHALL go to RECEIVE next cycle and clear the byte counter, word address and o_word_count to 0.
REQ-019 In RECEIVE, each i_rx_valid byte SHALL be shifted into a 32-bit assembly register, first byte becoming bits [31:24] (big-endian).
REQ-020 When the fourth byte of a word is accepted, the FSM SHALL go to WRITE and latch the assembled word into o_wr_data.
REQ-021 In WRITE, o_wr_en SHALL be 1 for exactly that one cycle, with o_wr_addr = 4*word_index; latency from the 4th-byte cycle to o_wr_en is one cycle.
REQ-022 A byte with i_rx_valid during WRITE SHALL be accepted as byte 0 of the next word; no byte is ever dropped.
REQ-023 After WRITE, o_word_count and the word index SHALL increment by 1 and o_wr_addr SHALL advance by 4.
REQ-024 If the written word equals HALT_WORD, the FSM SHALL go from WRITE to DONE; the halt word itself is stored.
REQ-025 Otherwise, if o_word_count reaches MEM_DEPTH, the FSM SHALL go from WRITE to ERROR.
REQ-026 Otherwise the FSM SHALL go from WRITE back to RECEIVE.
REQ-027 In DONE and ERROR, i_rx_valid bytes SHALL be ignored.
REQ-028 In DONE or ERROR, i_start SHALL restart a load as in REQ-018, overwriting from address 0.
REQ-029 i_start in RECEIVE or WRITE SHALL be ignored.
REQ-030 i_abort SHALL force IDLE next cycle from any state, discard any partial word and suppress any pending o_wr_en.
REQ-031 If i_abort and i_start are asserted together, i_abort SHALL win.
REQ-032 o_clear_pc SHALL be 1 in RECEIVE and WRITE, and 0 otherwise.
REQ-033 o_done SHALL be 1 only in DONE; o_error SHALL be 1 only in ERROR.
REQ-034 o_wr_addr SHALL never exceed 4*(MEM_DEPTH-1).

Reset
REQ-035 i_reset=1 SHALL asynchronously force IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_clear_pc=0, o_done=0, o_error=0, o_word_count=0 and the byte counter=0.
REQ-036 Reset asserted mid-load SHALL discard the partial word with no write.
REQ-037 After reset deasserts, the block SHALL wait in IDLE for i_start.

Verification
REQ-038 Bench SHALL cover: start, bytes 20,01,00,05 -> one o_wr_en, addr 0, data 32'h2001_0005, o_word_count=1, o_clear_pc=1.
REQ-039 Bench SHALL cover: two words, then FF,FF,FF,FF -> writes at 0, 4, 8; o_done=1, o_word_count=3, o_clear_pc=0.
REQ-040 Bench SHALL cover: MEM_DEPTH=4, four non-halt words -> last write at addr 12, then o_error=1; further bytes cause no write.
REQ-041 Bench SHALL cover: i_rx_valid in the WRITE cycle -> that byte appears as bits [31:24] of the next word.
REQ-042 Bench SHALL cover: abort, or asynchronous reset, after 2 bytes -> IDLE, no o_wr_en, outputs per REQ-035; a new start loads from address 0.
REQ-043 Bench SHALL cover: i_start in DONE -> reload overwrites from addr 0, o_done=0, o_word_count restarts at 0.
